// File: rtl/rng_sched_pkg.sv
// Shared types and helpers for the xorshift request scheduler.
// Holds the FSM state encoding, word widths and the seed derivation rule.
package rng_sched_pkg;

    localparam int RNG_W   = 128;
    localparam int EPOCH_W = 32;

    typedef enum logic [1:0] {
        LOAD,
        WARM,
        READY
    } state_t;

    function automatic logic [RNG_W-1:0] eff_seed(
        input logic [RNG_W-1:0]   seed,
        input logic [EPOCH_W-1:0] epoch
    );
        logic [RNG_W-1:0] s;
        s = seed ^ {{(RNG_W-EPOCH_W){1'b0}}, epoch};
        // An all-zero state is a fixed point of xorshift, so it is never loaded.
        return (s == '0) ? {{(RNG_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, searching upward with wrap-around.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               found
);

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] gnt_rot;

    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        req_rot = NUM_REQ'({req, req} >> ptr);
        gnt_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_rot[i] && !found) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Rotate the priority-encoded grant back into requester order.
        winner = NUM_REQ'(({gnt_rot, gnt_rot} << ptr) >> NUM_REQ);
    end

endmodule

// File: rtl/rng_request_scheduler.sv
// Seeds and warms up an external xorshift core, then hands out one fresh
// 128-bit word per request with round-robin fairness and periodic reseeding.
module rng_request_scheduler
    import rng_sched_pkg::*;
#(
    parameter int              NUM_REQ         = 2,
    parameter logic [RNG_W-1:0] SEED           = 128'h0000_0000_0000_0000_0000_0000_0000_0001,
    parameter int              WARMUP_CYCLES   = 16,
    parameter int              RESEED_INTERVAL = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RNG_W-1:0]   rnd_data,
    output logic               busy,
    output logic               rng_load,
    output logic [RNG_W-1:0]   rng_seed,
    output logic               rng_advance,
    input  logic [RNG_W-1:0]   rng_value
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [7:0]         warm_cnt;
    logic [31:0]        grant_cnt;
    logic [EPOCH_W-1:0] epoch;
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] winner;
    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               reseed_due;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_idx = PTR_W'(i);
        end
        next_ptr   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        reseed_due = (RESEED_INTERVAL != 0) &&
                     (grant_cnt + 32'd1 == 32'(RESEED_INTERVAL));
    end

    // Core controls are decoded straight from state so the core reacts on the
    // same edge that the FSM moves; a granted word is stepped past immediately.
    assign busy        = (state != READY);
    assign rng_load    = (state == LOAD);
    assign rng_seed    = eff_seed(SEED, epoch);
    assign rng_advance = (state == WARM) || ((state == READY) && found);

    // NOTE: all state here is sequential and uses non-blocking assignments, so
    // every right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            gnt       <= '0;
            rnd_data  <= '0;
            warm_cnt  <= '0;
            grant_cnt <= '0;
            epoch     <= '0;
            rr_ptr    <= '0;
        end else begin
            gnt      <= '0;
            rnd_data <= '0;
            case (state)
                LOAD: begin
                    warm_cnt <= 8'(WARMUP_CYCLES);
                    state    <= WARM;
                end
                WARM: begin
                    warm_cnt <= warm_cnt - 8'd1;
                    if (warm_cnt == 8'd1) state <= READY;
                end
                READY: begin
                    if (found) begin
                        gnt      <= winner;
                        rnd_data <= rng_value;
                        rr_ptr   <= next_ptr;
                        if (reseed_due) begin
                            grant_cnt <= '0;
                            epoch     <= epoch + 1'b1;
                            state     <= LOAD;
                        end else begin
                            grant_cnt <= grant_cnt + 32'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Scoreboard bench: two scheduler instances (reseeding and non-reseeding) fed
// random requests, each with its own xorshift core and a behavioural model.
module tb_rng_request_scheduler;

    typedef struct packed {
        bit [31:0]  edge_no;
        bit [7:0]   gnt;
        bit [127:0] data;
    } exp_t;

    localparam int         NR [2] = '{2, 3};
    localparam int         WM [2] = '{4, 6};
    localparam int         RI [2] = '{3, 0};
    localparam bit [127:0] SB [2] = '{128'h1, 128'h0};

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req0, gnt0;
    logic [2:0]   req1, gnt1;
    logic [127:0] rnd0, rnd1, seed0, seed1, core0, core1;
    logic         busy0, busy1, load0, load1, adv0, adv1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit [31:0]   edge_no  = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          seen1[bit [127:0]];

    int          hold   [2];
    int          ptr    [2];
    int          grants [2];
    bit [31:0]   epoch  [2];
    bit [127:0]  nxt    [2];

    always #5 clk = ~clk;

    rng_request_scheduler #(
        .NUM_REQ(2), .SEED(128'h1), .WARMUP_CYCLES(4), .RESEED_INTERVAL(3)
    ) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .gnt(gnt0), .rnd_data(rnd0),
        .busy(busy0), .rng_load(load0), .rng_seed(seed0), .rng_advance(adv0),
        .rng_value(core0)
    );

    rng_request_scheduler #(
        .NUM_REQ(3), .SEED(128'h0), .WARMUP_CYCLES(6), .RESEED_INTERVAL(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .gnt(gnt1), .rnd_data(rnd1),
        .busy(busy1), .rng_load(load1), .rng_seed(seed1), .rng_advance(adv1),
        .rng_value(core1)
    );

    // Marsaglia xorshift128 on four 32-bit words, x in the top word.
    function automatic bit [127:0] xs(input bit [127:0] s);
        bit [31:0] x, y, z, w, t;
        {x, y, z, w} = s;
        t = x ^ (x << 11);
        return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
    endfunction

    function automatic bit [127:0] eff(input bit [127:0] b, input bit [31:0] e);
        bit [127:0] s;
        s = b ^ {96'b0, e};
        return (s == 128'b0) ? 128'h1 : s;
    endfunction

    function automatic bit [127:0] warmed(input bit [127:0] s, input int n);
        bit [127:0] v;
        v = s;
        repeat (n) v = xs(v);
        return v;
    endfunction

    // External cores: load or step on the edge after the scheduler asks.
    always @(posedge clk) begin
        if (load0) core0 <= seed0; else if (adv0) core0 <= xs(core0);
        if (load1) core1 <= seed1; else if (adv1) core1 <= xs(core1);
    end

    task automatic check(input string name, input bit ok,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Behavioural model: hold counts edges until requests are honoured again.
    task automatic model_step(input int d, input bit rst, input bit [7:0] r);
        exp_t e;
        int   w;
        if (rst) begin
            hold[d]   = 1 + WM[d];
            ptr[d]    = 0;
            grants[d] = 0;
            epoch[d]  = 0;
            nxt[d]    = warmed(eff(SB[d], 0), WM[d]);
            if (d == 1) seen1.delete();
        end else if (hold[d] > 0) begin
            hold[d]--;
        end else if (r != 8'b0) begin
            w = -1;
            for (int i = 0; i < NR[d]; i++) begin
                if (w < 0 && r[(ptr[d] + i) % NR[d]]) w = (ptr[d] + i) % NR[d];
            end
            e.edge_no = edge_no + 1;
            e.gnt     = 8'(1) << w;
            e.data    = nxt[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            ptr[d] = (w + 1) % NR[d];
            if (RI[d] != 0 && grants[d] + 1 == RI[d]) begin
                epoch[d]++;
                grants[d] = 0;
                hold[d]   = 1 + WM[d];
                nxt[d]    = warmed(eff(SB[d], epoch[d]), WM[d]);
            end else begin
                grants[d]++;
                nxt[d] = xs(nxt[d]);
            end
        end
    endtask

    task automatic drive(input bit rst, input bit [1:0] r0, input bit [2:0] r1);
        @(negedge clk);
        reset = rst;
        req0  = r0;
        req1  = r1;
        model_step(0, rst, {6'b0, r0});
        model_step(1, rst, {5'b0, r1});
    endtask

    task automatic check_dut(input int d, input logic [7:0] g, input logic [127:0] data,
                             input logic b, input logic ld, input logic [127:0] sd,
                             input logic adv);
        exp_t e;
        bit   have;
        string p;
        p    = $sformatf("d%0d_", d);
        have = 1'b0;
        if (d == 0 && q0.size() > 0 && q0[0].edge_no == edge_no) begin
            e = q0.pop_front(); have = 1'b1;
        end
        if (d == 1 && q1.size() > 0 && q1[0].edge_no == edge_no) begin
            e = q1.pop_front(); have = 1'b1;
        end
        if (have) begin
            check({p, "gnt"}, g === e.gnt, 128'(g), 128'(e.gnt));
            check({p, "rnd_data"}, data === e.data, data, e.data);
            if (d == 1) begin
                check({p, "distinct"}, !seen1.exists(data), data, e.data);
                seen1[data] = 1'b1;
            end
        end else begin
            check({p, "no_gnt"}, g === 8'b0, 128'(g), 128'b0);
        end
        check({p, "busy"}, b === (hold[d] != 0), 128'(b), 128'(hold[d] != 0));
        check({p, "rng_load"}, ld === (hold[d] == 1 + WM[d]), 128'(ld),
              128'(hold[d] == 1 + WM[d]));
        if (hold[d] == 1 + WM[d])
            check({p, "rng_seed"}, sd === eff(SB[d], epoch[d]), sd, eff(SB[d], epoch[d]));
        if (hold[d] > 0 && hold[d] <= WM[d])
            check({p, "rng_advance"}, adv === 1'b1, 128'(adv), 128'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            check_dut(0, {6'b0, gnt0}, rnd0, busy0, load0, seed0, adv0);
            check_dut(1, {5'b0, gnt1}, rnd1, busy1, load1, seed1, adv1);
        end
    end

    initial begin
        reset = 1'b1;
        req0  = '0;
        req1  = '0;
        model_step(0, 1'b1, 8'b0);
        model_step(1, 1'b1, 8'b0);
        repeat (3) drive(1'b1, 2'b00, 3'b000);
        // All requests high from reset release: held off through LOAD/WARM,
        // then strict alternation once READY.
        repeat (40) drive(1'b0, 2'b11, 3'b111);
        repeat (300) drive(1'b0, 2'($urandom), 3'($urandom));
        // Reset lands on an edge where both instances would otherwise grant.
        drive(1'b1, 2'b11, 3'b111);
        repeat (200) drive(1'b0, 2'($urandom), 3'($urandom));
        repeat (1100) drive(1'b0, 2'($urandom), 3'b111);
        repeat (10) drive(1'b0, 2'b00, 3'b000);
        check("queues_drained", q0.size() == 0 && q1.size() == 0,
              128'(q0.size() + q1.size()), 128'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
